// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) SEC layout: widths, parity positions and the encoder.
// The decoder on the receive side imports this same package so both ends agree.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int PAR_W  = 5;
    localparam int ENC_W  = DATA_W + PAR_W;

    // Codeword bit indices (c[i] = position i+1) that hold parity bits.
    localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15};

    typedef logic [ENC_W-1:0] codeword_t;

    // Place the payload around the parity slots, then fill each slot with
    // even parity over the positions it covers.
    function automatic codeword_t hamming_encode(input logic [DATA_W-1:0] data);
        codeword_t c;
        c         = '0;
        c[2]      = data[0];
        c[6:4]    = data[3:1];
        c[14:8]   = data[10:4];
        c[20:16]  = data[15:11];
        c[PAR_IDX[0]] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14]
                      ^ c[16] ^ c[18] ^ c[20];
        c[PAR_IDX[1]] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14]
                      ^ c[17] ^ c[18];
        c[PAR_IDX[2]] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14]
                      ^ c[19] ^ c[20];
        c[PAR_IDX[3]] = ^c[14:8];
        c[PAR_IDX[4]] = ^c[20:16];
        return c;
    endfunction

endpackage

// File: rtl/ecc_fifo.sv
// Small synchronous FIFO for codewords. Storage is flops, so the head seen on
// dout_o is register-driven and holds still until a pop moves the read pointer.
module ecc_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers, cleared asynchronously so in-flight words are dropped.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/hamming_encode_tx.sv
// Transmit-side Hamming(21,16) encoder: valid/ready input, codeword FIFO on the
// output, one-shot single-bit error injection and an accepted-word counter.
module hamming_encode_tx
    import hamming_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [ENC_W-1:0]  encoded_data,
    output logic              valid_out,
    input  logic              ready_out,
    input  logic              inj_arm,
    input  logic [4:0]        inj_pos,
    output logic              inj_pending,
    output logic [CNT_W-1:0]  word_count
);

    logic             full, empty;
    logic             accept, pop;
    codeword_t        flip_mask, codeword;
    logic             inj_pending_q, inj_pending_d;
    logic [4:0]       inj_pos_q, inj_pos_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    assign ready_in    = !full;
    assign valid_out   = !empty;
    assign accept      = valid_in && ready_in;
    assign pop         = valid_out && ready_out;
    assign inj_pending = inj_pending_q;
    assign word_count  = word_count_q;

    // Build the codeword to store, flipping the armed bit when injection is pending.
    always_comb begin
        flip_mask = '0;
        if (inj_pending_q && (inj_pos_q < 5'(ENC_W))) flip_mask[inj_pos_q] = 1'b1;
        codeword = hamming_encode(data_in) ^ flip_mask;
    end

    // Injection arming and counter next state; a new arm always wins over consumption.
    always_comb begin
        inj_pending_d = inj_pending_q;
        inj_pos_d     = inj_pos_q;
        word_count_d  = word_count_q;
        if (inj_arm) begin
            inj_pending_d = 1'b1;
            inj_pos_d     = inj_pos;
        end else if (accept) begin
            inj_pending_d = 1'b0;
        end
        if (accept) word_count_d = word_count_q + CNT_W'(1);
    end

    // Injection and counter registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            inj_pending_q <= 1'b0;
            inj_pos_q     <= '0;
            word_count_q  <= '0;
        end else begin
            inj_pending_q <= inj_pending_d;
            inj_pos_q     <= inj_pos_d;
            word_count_q  <= word_count_d;
        end
    end

    ecc_fifo #(
        .WIDTH (ENC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (accept),
        .din_i   (codeword),
        .pop_i   (pop),
        .dout_o  (encoded_data),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_hamming_encode_tx.sv
// Self-checking bench for hamming_encode_tx against a positional Hamming model.
module tb_hamming_encode_tx;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [15:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out = 1'b0;
    logic        inj_arm = 1'b0;
    logic [4:0]  inj_pos = '0;
    logic        ready_in, valid_out, inj_pending;
    logic [20:0] encoded_data;
    logic [15:0] word_count;
    logic        ready_in4, valid_out4, inj_pending4;
    logic [20:0] encoded_data4;
    logic [3:0]  word_count4;

    int errors = 0;
    int checks = 0;

    logic [20:0] mq[$];
    logic [15:0] dq[$];
    bit          m_pend = 0;
    int          m_pos = 0;
    int unsigned m_cnt = 0;

    always #5 clk = ~clk;

    hamming_encode_tx #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rstb(rstb), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .encoded_data(encoded_data), .valid_out(valid_out),
        .ready_out(ready_out), .inj_arm(inj_arm), .inj_pos(inj_pos),
        .inj_pending(inj_pending), .word_count(word_count)
    );

    hamming_encode_tx #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rstb(rstb), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in4), .encoded_data(encoded_data4), .valid_out(valid_out4),
        .ready_out(ready_out), .inj_arm(inj_arm), .inj_pos(inj_pos),
        .inj_pending(inj_pending4), .word_count(word_count4)
    );

    // Positions 1..21; powers of two carry parity, the rest carry data in order.
    function automatic logic [20:0] ref_encode(input logic [15:0] d);
        logic [21:1] pb;
        int k;
        pb = '0;
        k = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                pb[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= 21; p++) if (((p >> j) & 1) == 1) par ^= pb[p];
            pb[1 << j] = par;
        end
        return pb;
    endfunction

    // Syndrome decoder: XOR of set positions names the flipped position.
    function automatic logic [15:0] ref_decode(input logic [20:0] cw);
        logic [21:1] pb;
        logic [15:0] d;
        int syn, k;
        pb = cw;
        syn = 0;
        for (int p = 1; p <= 21; p++) if (pb[p]) syn ^= p;
        if (syn >= 1 && syn <= 21) pb[syn] = ~pb[syn];
        k = 0;
        d = '0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = pb[p];
                k++;
            end
        end
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        dq.delete();
        m_pend = 0;
        m_pos = 0;
        m_cnt = 0;
    endtask

    // Advance one clock, updating the model from the inputs driven this cycle.
    task automatic cycle();
        bit acc, pp;
        logic [20:0] cw;
        acc = valid_in && (mq.size() < DEPTH);
        pp  = (mq.size() > 0) && ready_out;
        cw  = ref_encode(data_in);
        if (acc && m_pend && m_pos < 21) cw[m_pos] = ~cw[m_pos];
        if (inj_arm) begin
            m_pend = 1;
            m_pos  = int'(inj_pos);
        end else if (acc) begin
            m_pend = 0;
        end
        if (pp) begin
            void'(mq.pop_front());
            void'(dq.pop_front());
        end
        if (acc) begin
            mq.push_back(cw);
            dq.push_back(data_in);
            m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (encoded_data !== 21'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000000", encoded_data); end
        checks++; if (inj_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0", inj_pending); end
        checks++; if (word_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", word_count); end
        rstb = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (ready_in !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_in); end
    endtask

    task automatic test_basic();
        logic [15:0] vin [4];
        logic [20:0] vexp [4];
        vin  = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
        vexp = '{21'h000000, 21'h000007, 21'h108009, 21'h1FFFFE};
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = vin[i];
            valid_in = 1'b1;
            cycle();
            valid_in = 1'b0;
            checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", i, valid_out); end
            checks++; if (encoded_data !== vexp[i]) begin errors++; $display("[TB] FAIL basic_code[%0d]: got %h expected %h", i, encoded_data, vexp[i]); end
            checks++; if (encoded_data !== mq[0]) begin errors++; $display("[TB] FAIL basic_model[%0d]: got %h expected %h", i, encoded_data, mq[0]); end
        end
        cycle();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %b expected 0", valid_out); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 4", word_count); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [3];
        int idx;
        bit acc, done;
        w = '{16'h0001, 16'h0002, 16'h0003};
        idx = 0;
        ready_out = 1'b0;
        for (int c = 0; c < 4; c++) begin
            data_in = w[idx];
            valid_in = 1'b1;
            acc = (mq.size() < DEPTH);
            checks++; if (ready_in !== acc) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", c, ready_in, acc); end
            cycle();
            if (acc) idx++;
            checks++; if (encoded_data !== 21'h000007 || valid_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_head[%0d]: got %h/%b expected 000007/1", c, encoded_data, valid_out); end
        end
        checks++; if (idx != 2 || ready_in !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall: got accepts=%0d ready=%b expected 2/0", idx, ready_in); end
        ready_out = 1'b1;
        done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            checks++; if (valid_out !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected %b", c, valid_out, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if (encoded_data !== mq[0]) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", c, encoded_data, mq[0]); end
            end
            valid_in = (idx < 3);
            if (idx < 3) data_in = w[idx];
            acc = valid_in && (mq.size() < DEPTH);
            cycle();
            if (acc) idx++;
            if (idx == 3 && mq.size() == 0) done = 1;
        end
        valid_in = 1'b0;
        checks++; if (!done || word_count !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL bp_finish: got done=%0d count=%0d expected 1/%0d", done, word_count, m_cnt); end
    endtask

    task automatic test_inject();
        ready_out = 1'b1;
        inj_pos = 5'd5; inj_arm = 1'b1; valid_in = 1'b0;
        cycle();
        inj_arm = 1'b0;
        checks++; if (inj_pending !== 1'b1) begin errors++; $display("[TB] FAIL inj_armed: got %b expected 1", inj_pending); end
        data_in = 16'h0001; valid_in = 1'b1;
        cycle();
        checks++; if (encoded_data !== 21'h000027) begin errors++; $display("[TB] FAIL inj_flip: got %h expected 000027", encoded_data); end
        checks++; if (inj_pending !== 1'b0) begin errors++; $display("[TB] FAIL inj_clear: got %b expected 0", inj_pending); end
        cycle();
        checks++; if (encoded_data !== 21'h000007) begin errors++; $display("[TB] FAIL inj_oneshot: got %h expected 000007", encoded_data); end
        valid_in = 1'b0; inj_pos = 5'd25; inj_arm = 1'b1;
        cycle();
        inj_arm = 1'b0; valid_in = 1'b1;
        cycle();
        checks++; if (encoded_data !== 21'h000007 || inj_pending !== 1'b0) begin errors++; $display("[TB] FAIL inj_oob: got %h/%b expected 000007/0", encoded_data, inj_pending); end
        inj_pos = 5'd0; inj_arm = 1'b1;
        cycle();
        checks++; if (encoded_data !== 21'h000007 || inj_pending !== 1'b1) begin errors++; $display("[TB] FAIL inj_arm_accept: got %h/%b expected 000007/1", encoded_data, inj_pending); end
        inj_pos = 5'd2;
        cycle();
        checks++; if (encoded_data !== 21'h000006 || inj_pending !== 1'b1) begin errors++; $display("[TB] FAIL inj_rearm_accept: got %h/%b expected 000006/1", encoded_data, inj_pending); end
        inj_arm = 1'b0;
        cycle();
        checks++; if (encoded_data !== 21'h000003 || inj_pending !== 1'b0) begin errors++; $display("[TB] FAIL inj_newpos: got %h/%b expected 000003/0", encoded_data, inj_pending); end
        valid_in = 1'b0; inj_arm = 1'b1; inj_pos = 5'd1;
        cycle();
        inj_pos = 5'd4;
        cycle();
        inj_arm = 1'b0; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        checks++; if (encoded_data !== 21'h000017 || encoded_data !== mq[0]) begin errors++; $display("[TB] FAIL inj_overwrite: got %h expected 000017", encoded_data); end
        cycle();
    endtask

    task automatic test_loopback();
        int sent;
        bit acc;
        sent = 0;
        ready_out = 1'b1;
        for (int c = 0; c < 5000 && sent < 1000; c++) begin
            if (mq.size() > 0) begin
                checks++; if (encoded_data !== mq[0]) begin errors++; $display("[TB] FAIL loop_code[%0d]: got %h expected %h", c, encoded_data, mq[0]); end
                checks++; if (ref_decode(encoded_data) !== dq[0]) begin errors++; $display("[TB] FAIL loop_decode[%0d]: got %h expected %h", c, ref_decode(encoded_data), dq[0]); end
            end else begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL loop_idle[%0d]: got %b expected 0", c, valid_out); end
            end
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 16'($urandom);
            inj_arm  = ($urandom_range(0, 3) == 0);
            inj_pos  = 5'($urandom_range(0, 20));
            acc = valid_in && (mq.size() < DEPTH);
            cycle();
            if (acc) sent++;
        end
        valid_in = 1'b0; inj_arm = 1'b0;
        checks++; if (sent != 1000) begin errors++; $display("[TB] FAIL loop_budget: got %0d expected 1000", sent); end
        if (mq.size() > 0) begin
            checks++; if (ref_decode(encoded_data) !== dq[0]) begin errors++; $display("[TB] FAIL loop_last: got %h expected %h", ref_decode(encoded_data), dq[0]); end
        end
        cycle();
        checks++; if (word_count !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL loop_count: got %0d expected %0d", word_count, m_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [20:0] exp;
        ready_out = 1'b0;
        valid_in = 1'b1; data_in = 16'h1234;
        cycle();
        data_in = 16'h5678;
        cycle();
        valid_in = 1'b0; inj_arm = 1'b1; inj_pos = 5'd3;
        cycle();
        inj_arm = 1'b0;
        checks++; if (ready_in !== 1'b0 || inj_pending !== 1'b1) begin errors++; $display("[TB] FAIL mid_setup: got ready=%b pend=%b expected 0/1", ready_in, inj_pending); end
        #2 rstb = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || inj_pending !== 1'b0 || word_count !== 16'h0 || encoded_data !== 21'h0) begin
            errors++; $display("[TB] FAIL mid_reset: got v=%b p=%b cnt=%0d d=%h expected 0/0/0/000000", valid_out, inj_pending, word_count, encoded_data);
        end
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        ready_out = 1'b1;
        @(negedge clk);
        checks++; if (ready_in !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", ready_in); end
        data_in = 16'hABCD; valid_in = 1'b1;
        exp = ref_encode(16'hABCD);
        cycle();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || encoded_data !== exp) begin errors++; $display("[TB] FAIL mid_first: got %b/%h expected 1/%h", valid_out, encoded_data, exp); end
        cycle();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rstb = 1'b0;
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        ready_out = 1'b1;
        for (int i = 0; i < 17; i++) begin
            valid_in = 1'b1;
            data_in = 16'($urandom);
            cycle();
        end
        valid_in = 1'b0;
        checks++; if (word_count4 !== 4'd1) begin errors++; $display("[TB] FAIL wrap_cnt4: got %0d expected 1", word_count4); end
        checks++; if (word_count !== 16'd17) begin errors++; $display("[TB] FAIL wrap_cnt16: got %0d expected 17", word_count); end
    endtask

    // Sequence of scenarios, then the summary.
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_inject();
        test_loopback();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
